// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: polarity levels and the 640x480@60 / 800x600@60 preset sets.
package vga_timing_pkg;

    localparam logic POL_LOW  = 1'b0;
    localparam logic POL_HIGH = 1'b1;

    // 640x480@60, 25 MHz pixel rate, both syncs active-low
    localparam int VGA640_H_FP   = 16;
    localparam int VGA640_H_SYNC = 96;
    localparam int VGA640_H_BP   = 48;
    localparam int VGA640_H_ACT  = 640;
    localparam int VGA640_V_FP   = 10;
    localparam int VGA640_V_SYNC = 2;
    localparam int VGA640_V_BP   = 33;
    localparam int VGA640_V_ACT  = 480;

    // 800x600@60, 40 MHz pixel rate, both syncs active-high
    localparam int SVGA800_H_FP   = 40;
    localparam int SVGA800_H_SYNC = 128;
    localparam int SVGA800_H_BP   = 88;
    localparam int SVGA800_H_ACT  = 800;
    localparam int SVGA800_V_FP   = 1;
    localparam int SVGA800_V_SYNC = 4;
    localparam int SVGA800_V_BP   = 23;
    localparam int SVGA800_V_ACT  = 600;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync and coordinate decode.
// 'active' reports the active flag as it stands after the current edge (held when en=0).
module vga_axis_counter #(
    parameter int   CW   = 10,
    parameter int   FP   = 16,
    parameter int   SYNC = 96,
    parameter int   BP   = 48,
    parameter int   ACT  = 640,
    parameter logic POL  = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          sync,
    output logic          active,
    output logic [CW-1:0] coord
);
    localparam int TOTAL  = FP + SYNC + BP + ACT;
    localparam int ASTART = FP + SYNC + BP;

    logic [CW-1:0] nxt;
    logic          act_nxt;
    logic          sync_nxt;
    logic          active_q;

    assign wrap     = (count == CW'(TOTAL - 1));
    assign nxt      = wrap ? '0 : count + CW'(1);
    assign act_nxt  = (nxt >= CW'(ASTART));
    assign sync_nxt = (nxt >= CW'(FP)) && (nxt < CW'(FP + SYNC));
    assign active   = en ? act_nxt : active_q;

    // Decode is taken from the next count so outputs land with the counter, not a cycle behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            sync     <= ~POL;
            active_q <= 1'b0;
            coord    <= '0;
        end else if (en) begin
            count    <= nxt;
            sync     <= sync_nxt ? POL : ~POL;
            active_q <= act_nxt;
            coord    <= act_nxt ? nxt - CW'(ASTART) : '0;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: H/V axis counters plus line/frame strobes.
// Optional 16-bit frame counter output enabled by VGA_FRAME_CNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CW     = 10,
    parameter int   H_FP   = VGA640_H_FP,
    parameter int   H_SYNC = VGA640_H_SYNC,
    parameter int   H_BP   = VGA640_H_BP,
    parameter int   H_ACT  = VGA640_H_ACT,
    parameter int   V_FP   = VGA640_V_FP,
    parameter int   V_SYNC = VGA640_V_SYNC,
    parameter int   V_BP   = VGA640_V_BP,
    parameter int   V_ACT  = VGA640_V_ACT,
    parameter logic H_POL  = POL_LOW,
    parameter logic V_POL  = POL_LOW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_pix_clk,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_active,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_line,
    output logic          o_frame
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]   o_frame_cnt
`endif
);
    localparam int H_TOTAL = H_FP + H_SYNC + H_BP + H_ACT;
    localparam int V_TOTAL = V_FP + V_SYNC + V_BP + V_ACT;

    if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 2^CW");
    end
    if (H_FP == 0 || V_FP == 0) begin : g_bad_fp
        $error("vga_timing_gen: front porch must be at least 1");
    end

    logic [CW-1:0] h_cnt, v_cnt;
    logic          h_wrap, v_wrap;
    logic          h_active, v_active;
    logic          v_en;
    logic          cnt_unused;

    assign v_en       = i_pix_clk & h_wrap;
    assign cnt_unused = ^{h_cnt, v_cnt};

    vga_axis_counter #(
        .CW(CW), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT), .POL(H_POL)
    ) u_h (
        .clk(i_clk), .rst(i_rst), .en(i_pix_clk),
        .count(h_cnt), .wrap(h_wrap), .sync(o_hsync), .active(h_active), .coord(o_x)
    );

    vga_axis_counter #(
        .CW(CW), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT), .POL(V_POL)
    ) u_v (
        .clk(i_clk), .rst(i_rst), .en(v_en),
        .count(v_cnt), .wrap(v_wrap), .sync(o_vsync), .active(v_active), .coord(o_y)
    );

    // Pulses are recomputed every clock so they self-clear when the strobe is absent.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_active <= 1'b0;
            o_line   <= 1'b0;
            o_frame  <= 1'b0;
        end else begin
            o_line  <= v_en;
            o_frame <= v_en & v_wrap;
            if (i_pix_clk)
                o_active <= h_active & v_active;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_frame_cnt <= '0;
        else if (v_en && v_wrap)
            o_frame_cnt <= o_frame_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing for line-level checks, and a tiny
// active-high-sync raster (10x7) for frame, wrap and mid-frame reset checks.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Default 640x480 instance
    logic       rst = 1'b1, pix = 1'b0;
    logic       hs, vs, act, line, frame;
    logic [9:0] x, y;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fcnt;
`endif

    vga_timing_gen dut (
        .i_clk(clk), .i_rst(rst), .i_pix_clk(pix),
        .o_hsync(hs), .o_vsync(vs), .o_active(act), .o_x(x), .o_y(y),
        .o_line(line), .o_frame(frame)
`ifdef VGA_FRAME_CNT_EN
        , .o_frame_cnt(fcnt)
`endif
    );

    // Tiny raster: H 2/3/1/4 (total 10, active from 6), V 1/2/1/3 (total 7, active from 4)
    logic       rst_s = 1'b1, pix_s = 1'b0;
    logic       hs_s, vs_s, act_s, line_s, frame_s;
    logic [3:0] x_s, y_s;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fcnt_s;
`endif

    vga_timing_gen #(
        .CW(4), .H_FP(2), .H_SYNC(3), .H_BP(1), .H_ACT(4),
        .V_FP(1), .V_SYNC(2), .V_BP(1), .V_ACT(3), .H_POL(1'b1), .V_POL(1'b1)
    ) dut_s (
        .i_clk(clk), .i_rst(rst_s), .i_pix_clk(pix_s),
        .o_hsync(hs_s), .o_vsync(vs_s), .o_active(act_s), .o_x(x_s), .o_y(y_s),
        .o_line(line_s), .o_frame(frame_s)
`ifdef VGA_FRAME_CNT_EN
        , .o_frame_cnt(fcnt_s)
`endif
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // n single-cycle strobes, each followed by 'gap' idle cycles
    task automatic strobes(input int n, input int gap);
        repeat (n) begin
            pix = 1'b1;
            cyc(1);
            pix = 1'b0;
            cyc(gap);
        end
    endtask

    int n;

    initial begin
        // ---------------- default timing ----------------
        cyc(2);
        rst = 1'b0;
        chk("rst_hsync", hs, 1);
        chk("rst_vsync", vs, 1);
        chk("rst_active", act, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_line", line, 0);
        chk("rst_frame", frame, 0);
`ifdef VGA_FRAME_CNT_EN
        chk("rst_fcnt", fcnt, 0);
`endif
        strobes(15, 3);
        chk("h15_hsync", hs, 1);
        strobes(1, 3);
        chk("h16_hsync", hs, 0);
        strobes(95, 3);
        chk("h111_hsync", hs, 0);
        strobes(1, 3);
        chk("h112_hsync", hs, 1);
        strobes(49, 3);
        chk("h161_x", x, 1);
        chk("h161v0_active", act, 0);
        strobes(638, 3);
        chk("h799_x", x, 639);
        chk("h799_line", line, 0);
        pix = 1'b1;
        cyc(1);
        pix = 1'b0;
        chk("wrap_line", line, 1);
        chk("wrap_x", x, 0);
        chk("wrap_frame", frame, 0);
        cyc(1);
        chk("line_clear", line, 0);

        // strobe tied high from here: (0,1) -> next line pulse
        pix = 1'b1;
        n = 0;
        for (int i = 1; i <= 1000; i++) begin
            cyc(1);
            if (line) begin
                n = i;
                break;
            end
        end
        chk("line_period", n, 800);
        cyc(1);
        chk("line_width", line, 0);
        cyc(6399);                    // (0,10)
        chk("v10_vsync", vs, 0);
        chk("v10_line", line, 1);
        cyc(1599);                    // (799,11)
        chk("v11_vsync", vs, 0);
        cyc(1);                       // (0,12)
        chk("v12_vsync", vs, 1);
        cyc(26559);                   // (159,45)
        chk("h159v45_active", act, 0);
        cyc(1);                       // (160,45)
        chk("h160v45_active", act, 1);
        chk("h160v45_x", x, 0);
        chk("h160v45_y", y, 0);
        pix = 1'b0;
        cyc(50);
        chk("hold_active", act, 1);
        chk("hold_x", x, 0);
        chk("hold_line", line, 0);
        strobes(1, 0);
        chk("resume_x", x, 1);

        // ---------------- tiny raster ----------------
        rst_s = 1'b0;
        chk("s_rst_hsync", hs_s, 0);
        chk("s_rst_vsync", vs_s, 0);
        chk("s_rst_active", act_s, 0);
        pix_s = 1'b1;
        cyc(1);                       // (1,0)
        chk("s_h1_hsync", hs_s, 0);
        cyc(1);                       // (2,0)
        chk("s_h2_hsync", hs_s, 1);
        cyc(3);                       // (5,0)
        chk("s_h5_hsync", hs_s, 0);
        cyc(5);                       // (0,1)
        chk("s_v1_vsync", vs_s, 1);
        chk("s_v1_line", line_s, 1);
        cyc(36);                      // (6,4)
        chk("s_first_active", act_s, 1);
        chk("s_first_x", x_s, 0);
        chk("s_first_y", y_s, 0);
        cyc(23);                      // (9,6)
        chk("s_last_x", x_s, 3);
        chk("s_last_y", y_s, 2);
        chk("s_last_vsync", vs_s, 0);
        cyc(1);                       // (0,0)
        chk("s_frame", frame_s, 1);
        chk("s_frame_line", line_s, 1);
        chk("s_frame_x", x_s, 0);
        chk("s_frame_y", y_s, 0);
        chk("s_frame_active", act_s, 0);
`ifdef VGA_FRAME_CNT_EN
        chk("s_fcnt1", fcnt_s, 1);
`endif
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            cyc(1);
            if (frame_s) begin
                n = i;
                break;
            end
        end
        chk("s_frame_period", n, 70);
`ifdef VGA_FRAME_CNT_EN
        chk("s_fcnt2", fcnt_s, 2);
`endif
        cyc(1);                       // (1,0)
        chk("s_frame_width", frame_s, 0);
        cyc(56);                      // (7,5)
        chk("s_mid_active", act_s, 1);
        chk("s_mid_x", x_s, 1);
        chk("s_mid_y", y_s, 1);
        rst_s = 1'b1;                 // reset coincides with a strobe
        cyc(1);
        rst_s = 1'b0;
        chk("s_mrst_active", act_s, 0);
        chk("s_mrst_x", x_s, 0);
        chk("s_mrst_y", y_s, 0);
        chk("s_mrst_hsync", hs_s, 0);
        chk("s_mrst_frame", frame_s, 0);
        chk("s_mrst_line", line_s, 0);
`ifdef VGA_FRAME_CNT_EN
        chk("s_mrst_fcnt", fcnt_s, 0);
`endif
        cyc(1);                       // (1,0)
        chk("s_after_frame", frame_s, 0);
        cyc(1);                       // (2,0)
        chk("s_after_hsync", hs_s, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
